// File: rtl/debug_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : debug_sequencer
//  Description : Front-end controller for the 5-stage MIPS pipeline. Accepts
//                command bytes from a UART receiver, loads the program into
//                instruction memory, runs the pipeline continuously or one
//                step at a time, and reports PC and cycle count over a
//                valid/ready byte transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_sequencer #(
    parameter int         MAX_WORDS  = 256,
    parameter logic [7:0] CMD_LOAD   = 8'h4C,
    parameter logic [7:0] CMD_CONT   = 8'h43,
    parameter logic [7:0] CMD_STEP   = 8'h53,
    parameter logic [7:0] CMD_REPORT = 8'h52
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_halt,
    input  logic [31:0] i_pc,
    input  logic        i_tx_ready,
    output logic        o_write_instruction_mem,
    output logic [31:0] o_instruction_mem_addr,
    output logic [31:0] o_instruction_mem_data,
    output logic        o_pipe_enable,
    output logic        o_pipe_reset,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    output logic        o_busy
);

    // Word index wide enough to address MAX_WORDS words (MAX_WORDS >= 2).
    localparam int c_IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_LOAD_COUNT = 3'd1;
    localparam logic [2:0] c_LOAD_BYTE  = 3'd2;
    localparam logic [2:0] c_RUN        = 3'd3;
    localparam logic [2:0] c_STEP       = 3'd4;
    localparam logic [2:0] c_REPORT     = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic               r_halted;
    logic [31:0]        r_cycle_cnt;
    logic [31:0]        w_cycle_cnt_next;
    logic [c_IDX_W-1:0] r_word_idx;
    logic [c_IDX_W-1:0] r_last_idx;
    logic [c_IDX_W-1:0] w_last_idx;
    logic [31:0]        w_n_sat;
    logic [1:0]         r_byte_idx;
    logic [23:0]        r_word_lo;
    logic [63:0]        r_report;
    logic [2:0]         r_tx_idx;
    logic               w_tx_fire;
    logic               r_wr;
    logic [31:0]        r_addr;
    logic [31:0]        r_data;
    logic               r_pipe_enable;
    logic               r_pipe_reset;
    logic               r_tx_valid;
    logic               r_busy;

    assign o_write_instruction_mem = r_wr;
    assign o_instruction_mem_addr  = r_addr;
    assign o_instruction_mem_data  = r_data;
    assign o_pipe_enable           = r_pipe_enable;
    assign o_pipe_reset            = r_pipe_reset;
    assign o_tx_data               = r_report[7:0];
    assign o_tx_valid              = r_tx_valid;
    assign o_busy                  = r_busy;

    // Datapath helpers: counter advance, tx handshake, saturated word count.
    always_comb begin
        w_cycle_cnt_next = r_pipe_enable ? (r_cycle_cnt + 32'd1) : r_cycle_cnt;
        w_tx_fire        = r_tx_valid & i_tx_ready;
        w_n_sat          = ({24'd0, i_rx_data} > 32'(MAX_WORDS)) ? 32'(MAX_WORDS)
                                                                 : {24'd0, i_rx_data};
        w_last_idx       = c_IDX_W'(w_n_sat - 32'd1);
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD) begin
                        w_state_next = c_LOAD_COUNT;
                    end else if (i_rx_data == CMD_CONT) begin
                        w_state_next = r_halted ? c_REPORT : c_RUN;
                    end else if (i_rx_data == CMD_STEP) begin
                        w_state_next = r_halted ? c_REPORT : c_STEP;
                    end else if (i_rx_data == CMD_REPORT) begin
                        w_state_next = c_REPORT;
                    end
                end
            end
            c_LOAD_COUNT: begin
                if (i_rx_valid) begin
                    w_state_next = (i_rx_data == 8'd0) ? c_IDLE : c_LOAD_BYTE;
                end
            end
            c_LOAD_BYTE: begin
                if (i_rx_valid && (r_byte_idx == 2'd3) && (r_word_idx == r_last_idx)) begin
                    w_state_next = c_IDLE;
                end
            end
            c_RUN: begin
                if (i_halt) begin
                    w_state_next = c_REPORT;
                end
            end
            c_STEP: begin
                w_state_next = c_REPORT;
            end
            c_REPORT: begin
                if (w_tx_fire && (r_tx_idx == 3'd7)) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // State, control outputs, program loading and report serialisation.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= c_IDLE;
            r_halted      <= 1'b0;
            r_cycle_cnt   <= 32'd0;
            r_word_idx    <= '0;
            r_last_idx    <= '0;
            r_byte_idx    <= 2'd0;
            r_word_lo     <= 24'd0;
            r_report      <= 64'd0;
            r_tx_idx      <= 3'd0;
            r_wr          <= 1'b0;
            r_addr        <= 32'd0;
            r_data        <= 32'd0;
            r_pipe_enable <= 1'b0;
            r_pipe_reset  <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_busy        <= (w_state_next != c_IDLE);
            // Enable is high exactly while the FSM sits in RUN or STEP.
            r_pipe_enable <= (w_state_next == c_RUN) || (w_state_next == c_STEP);
            r_wr          <= 1'b0;
            r_pipe_reset  <= 1'b0;
            r_cycle_cnt   <= w_cycle_cnt_next;

            // The halt cycle itself is an enabled, counted cycle.
            if (r_pipe_enable && i_halt) begin
                r_halted <= 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (i_rx_valid && (i_rx_data == CMD_LOAD)) begin
                        r_pipe_reset <= 1'b1;
                        r_halted     <= 1'b0;
                        r_cycle_cnt  <= 32'd0;
                        r_word_idx   <= '0;
                    end
                end
                c_LOAD_COUNT: begin
                    if (i_rx_valid) begin
                        r_last_idx <= w_last_idx;
                        r_byte_idx <= 2'd0;
                    end
                end
                c_LOAD_BYTE: begin
                    if (i_rx_valid) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0:    r_word_lo[7:0]   <= i_rx_data;
                            2'd1:    r_word_lo[15:8]  <= i_rx_data;
                            2'd2:    r_word_lo[23:16] <= i_rx_data;
                            default: begin
                                r_wr       <= 1'b1;
                                r_addr     <= {{(30 - c_IDX_W){1'b0}}, r_word_idx, 2'b00};
                                r_data     <= {i_rx_data, r_word_lo};
                                r_word_idx <= r_word_idx + c_IDX_W'(1);
                            end
                        endcase
                    end
                end
                c_REPORT: begin
                    // Shift the next byte down to the output slot once accepted.
                    if (w_tx_fire) begin
                        r_report <= {8'd0, r_report[63:8]};
                        r_tx_idx <= r_tx_idx + 3'd1;
                        if (r_tx_idx == 3'd7) begin
                            r_tx_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase

            // Snapshot PC and the post-increment count on entry to REPORT.
            if ((r_state != c_REPORT) && (w_state_next == c_REPORT)) begin
                r_report   <= {w_cycle_cnt_next, i_pc};
                r_tx_idx   <= 3'd0;
                r_tx_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/debug_sequencer.md
Name: debug_sequencer

Overview:
- Front-end controller for the 5-stage MIPS pipeline.
- Takes command bytes from a byte-stream receiver (the UART RX side).
- Loads the program into instruction memory through the fetch stage's write port.
- Sequences execution in continuous or single-step mode by driving a pipeline clock-enable, then reports PC and cycle count over a byte-stream transmitter with valid/ready handshake.

Parameters:
- MAX_WORDS, 256, maximum program length in 32-bit words; also the width source for the word index (log2).
- CMD_LOAD, 8'h4C, command byte 'L'.
- CMD_CONT, 8'h43, command byte 'C'.
- CMD_STEP, 8'h53, command byte 'S'.
- CMD_REPORT, 8'h52, command byte 'R'.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous reset, active-high.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe, byte valid; always accepted when the FSM is listening.
- i_halt  in  1  HALT decoded by the pipeline.
- i_pc  in  32  current fetch PC.
- i_tx_ready  in  1  transmitter can accept a byte.
- o_write_instruction_mem  out  1  one-cycle instruction memory write strobe.
- o_instruction_mem_addr  out  32  byte address for the write (word_idx*4).
- o_instruction_mem_data  out  32  instruction word to write.
- o_pipe_enable  out  1  pipeline clock-enable.
- o_pipe_reset  out  1  one-cycle pipeline reset pulse.
- o_tx_data  out  8  byte to transmit.
- o_tx_valid  out  1  o_tx_data valid.
- o_busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (sync, any state): FSM goes to IDLE. All outputs go to 0. Cycle counter, word index, byte index and halted flag clear. Any in-flight write strobe or tx byte is dropped.
- States: IDLE, LOAD_COUNT, LOAD_BYTE, RUN, STEP, REPORT.
- IDLE, on i_rx_valid:
  - CMD_LOAD -> LOAD_COUNT. o_pipe_reset=1 for the next cycle. The same cycle clears halted, the cycle counter and the word index.
  - CMD_CONT -> RUN, or straight to REPORT if halted.
  - CMD_STEP -> STEP.
  - CMD_REPORT -> REPORT.
  - Any other byte is ignored; stay in IDLE.
- LOAD_COUNT: the next accepted byte is N (number of words).
  - N=0 -> IDLE with no writes.
  - N is saturated to MAX_WORDS.
  - Otherwise -> LOAD_BYTE with byte index 0.
- LOAD_BYTE: bytes are assembled little-endian (first byte = bits[7:0]).
  - On the 4th byte, o_write_instruction_mem=1 for exactly one cycle on the following edge, with addr={word_idx,2'b00} and the assembled data. word_idx then increments.
  - The FSM stays in LOAD_BYTE and accepts the next byte in that same cycle; no byte is lost.
  - After word N-1 is written -> IDLE.
- RUN: o_pipe_enable=1 every cycle; the 32-bit cycle counter increments per enabled cycle and wraps.
  - i_halt=1 while enabled -> set halted, go to REPORT.
  - o_pipe_enable is 0 from the next cycle; the halt cycle itself is counted.
- STEP:
  - If halted -> REPORT with no enable.
  - Else o_pipe_enable=1 for exactly one cycle, counter+1, and halted is set if i_halt is seen; then -> REPORT.
- REPORT: i_pc and the counter are snapshotted on entry. 8 bytes are sent: PC[7:0] .. PC[31:24], then CNT[7:0] .. CNT[31:24].
  - o_tx_valid/o_tx_data are held stable until i_tx_ready=1 in the same cycle; the next byte is presented on the following cycle.
  - After the 8th transfer -> IDLE and o_tx_valid=0.
- i_rx_valid in RUN, STEP and REPORT is ignored (byte discarded).
- halted clears only on reset or CMD_LOAD.
- o_busy = (state != IDLE), registered.
- o_pipe_enable is never high in IDLE, LOAD_* or REPORT.
- o_write_instruction_mem is never high outside the cycle after a 4th byte.

Test Plan:
- Load 2 words: 'L', 0x02, bytes 13 00 04 20 EF BE AD DE.
  - Write pulses: addr 0x0 / 0x20040013, then addr 0x4 / 0xDEADBEEF, each exactly 1 cycle.
  - One o_pipe_reset pulse after 'L'; o_busy falls after the 2nd write.
- 'C' with i_halt forced high on the 5th enabled cycle, i_pc=0x14.
  - o_pipe_enable high for exactly 5 cycles.
  - TX sequence 14 00 00 00 05 00 00 00.
- 'S' twice from fresh load: one enable cycle each; reports show CNT=1, then CNT=2. After halt, 'S' gives no enable and the report repeats the same CNT.
- REPORT with i_tx_ready toggling 1/0 every cycle: each byte held stable until accepted; exactly 8 transfers; no byte duplicated or skipped.
- Unknown byte 0x41 in IDLE -> no output change. 'L', 0x00 -> no write strobe, back to IDLE.
- Reset asserted after the 2nd data byte of a load: next cycle IDLE, all outputs 0. A new load writes starting at addr 0x0.
